frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 The block SHALL have parameter MAX_MODELS, default 64, meaning the maximum number of models drawn per frame.
REQ-002 The block SHALL have parameter MODEL_W, default $clog2(MAX_MODELS+1), meaning the width of the model count and index.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 2**20, meaning the per-model watchdog limit in clocks.
REQ-004 Port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port i_frame_start  in  1  single-cycle pulse requesting one frame.
REQ-007 Port i_model_count  in  MODEL_W  number of models for the frame, sampled on the accepted i_frame_start.
REQ-008 Port o_busy  out  1  high whenever the state is not IDLE.
REQ-009 Port o_clear_start / i_clear_done  out/in  1/1  framebuffer clear pulse and its completion pulse.
REQ-010 Port o_render_start  out  1  single-cycle start pulse to the render pipeline.
REQ-011 Port i_render_ready  in  1  render pipeline can accept a start.
REQ-012 Port i_render_finished  in  1  latched finish flag from the render pipeline; it clears the cycle after a start.
REQ-013 Port o_model_idx  out  MODEL_W  index of the model currently in flight; it selects the MVP/model-buffer source.
REQ-014 Port o_swap_req / i_swap_ack  out/in  1/1  buffer-swap request (level) and its acknowledge.
REQ-015 Port o_frame_done  out  1  single-cycle pulse at frame completion.
REQ-016 Port o_overrun  out  1  single-cycle pulse when i_frame_start arrives while busy.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, CLEAR, WAIT_READY, START, RENDER, SWAP, DONE.
REQ-018 IDLE SHALL go to CLEAR on i_frame_start, latch i_model_count, zero o_model_idx, and pulse o_clear_start in the same cycle the CLEAR state is entered.
REQ-019 CLEAR SHALL wait for i_clear_done; a latched count of 0 SHALL then go directly to SWAP, otherwise to WAIT_READY.
REQ-020 WAIT_READY SHALL go to START when i_render_ready is 1.
REQ-021 START SHALL last one cycle, assert o_render_start for that cycle, and go to RENDER.
REQ-022 RENDER SHALL ignore i_render_finished in its first cycle and act on it from its second cycle onward, so a stale latched finish is never taken.
REQ-023 On an accepted finish, RENDER SHALL increment o_model_idx and go to WAIT_READY if idx+1 < count, else to SWAP.
REQ-024 SWAP SHALL hold o_swap_req high until the cycle i_swap_ack is 1, then go to DONE.
REQ-025 DONE SHALL last one cycle, pulse o_frame_done, and return to IDLE.
REQ-026 i_frame_start received in any state other than IDLE SHALL be dropped and SHALL pulse o_overrun the next cycle.
REQ-027 i_model_count greater than MAX_MODELS SHALL be saturated to MAX_MODELS when latched.
REQ-028 i_clear_done and i_swap_ack asserted outside CLEAR and SWAP respectively SHALL be ignored.

Reset
REQ-029 While rst is 1, the FSM SHALL go to IDLE and every output SHALL be 0, including o_model_idx; the latched count and the timer SHALL clear.
REQ-030 Reset mid-frame SHALL abort the frame without pulsing o_frame_done.

Configuration
REQ-031 With FRAME_SCHED_TIMEOUT_EN defined, a counter SHALL run in RENDER and in WAIT_READY. On reaching TIMEOUT_CYCLES it SHALL pulse output o_timeout (1 bit) and skip the current model as if it had finished.
REQ-032 Without FRAME_SCHED_TIMEOUT_EN, neither o_timeout nor the counter SHALL exist, and RENDER SHALL wait indefinitely.

Structure
REQ-033 The state enum and a default MAX_MODELS constant SHALL live in shared package render_pkg.
REQ-034 The watchdog SHALL be a sub-module, sched_watchdog (clear, enable, expire), instantiated only under the macro.

Verification
REQ-035 Reset: hold rst for 3 cycles mid-RENDER -> IDLE, all outputs 0, no o_frame_done.
REQ-036 Count=3, ready always 1, finish 10 cycles after each start -> exactly 3 o_render_start pulses with o_model_idx 0, 1, 2, then o_swap_req, then 1 o_frame_done.
REQ-037 Count=0 -> o_clear_start, then o_swap_req; ack -> o_frame_done; zero o_render_start pulses.
REQ-038 i_render_finished held at 1 from the previous frame, count=1 -> the start is issued and the finish is not taken in the first RENDER cycle.
REQ-039 i_frame_start during RENDER -> o_overrun pulses once, frame continues unaffected.
REQ-040 With macro, TIMEOUT_CYCLES=16, count=2, no finish -> o_timeout pulses twice, o_frame_done follows.

Source files
------------

// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : render_pkg
//  Purpose  : Shared frame-scheduler types and constants: scheduler state
//             encoding and the default per-frame model limit.
//  Revision : 1.0  initial release
// ============================================================================
package render_pkg;

    // Default upper bound on the number of models drawn in one frame
    localparam int c_MAX_MODELS_DEFAULT = 64;

    // Frame scheduler states, explicitly encoded on 3 bits
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        WAIT_READY = 3'd2,
        START      = 3'd3,
        RENDER     = 3'd4,
        SWAP       = 3'd5,
        DONE       = 3'd6
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sched_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : sched_watchdog
//  Purpose  : Per-model watchdog. Counts enabled cycles since the last clear
//             and flags expiry once TIMEOUT_CYCLES enabled cycles have passed.
//             Only instantiated when FRAME_SCHED_TIMEOUT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles, saturating at the limit so the flag cannot wrap
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire = i_enable && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : frame_scheduler
//  Purpose  : Sequences one frame: framebuffer clear, one render start per
//             model (with stale-finish protection), buffer swap, done pulse.
//             Optional macro FRAME_SCHED_TIMEOUT_EN adds a per-model watchdog
//             with an o_timeout pulse; a timed-out model is skipped.
//  Revision : 1.0  initial release
// ============================================================================
module frame_scheduler
    import render_pkg::*;
#(
    parameter int MAX_MODELS     = c_MAX_MODELS_DEFAULT,
    parameter int MODEL_W        = $clog2(MAX_MODELS + 1),
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_frame_start,
    input  logic [MODEL_W-1:0] i_model_count,
    output logic               o_busy,
    output logic               o_clear_start,
    input  logic               i_clear_done,
    output logic               o_render_start,
    input  logic               i_render_ready,
    input  logic               i_render_finished,
    output logic [MODEL_W-1:0] o_model_idx,
    output logic               o_swap_req,
    input  logic               i_swap_ack,
    output logic               o_frame_done,
    output logic               o_overrun
`ifdef FRAME_SCHED_TIMEOUT_EN
    ,
    output logic               o_timeout
`endif
);

    localparam logic [MODEL_W-1:0] c_MAX_COUNT = MODEL_W'(MAX_MODELS);

    sched_state_t       r_state;
    logic [MODEL_W-1:0] r_count;
    logic [MODEL_W-1:0] r_model_idx;
    logic               r_render_first;
    logic               r_clear_start;
    logic               r_render_start;
    logic               r_swap_req;
    logic               r_frame_done;
    logic               r_overrun;

    logic [MODEL_W-1:0] w_count_sat;
    logic [MODEL_W-1:0] w_next_idx;
    logic               w_advance;

    assign w_count_sat = (i_model_count > c_MAX_COUNT) ? c_MAX_COUNT : i_model_count;
    assign w_next_idx  = r_model_idx + MODEL_W'(1);

`ifdef FRAME_SCHED_TIMEOUT_EN
    logic w_expire;
    logic w_wd_enable;
    logic w_wd_clear;
    logic r_timeout;

    // The watchdog runs while a model is pending; START holds the count so
    // time spent waiting for ready and rendering both charge the same model.
    assign w_wd_enable = (r_state == WAIT_READY) || (r_state == RENDER);
    assign w_wd_clear  = w_advance || !(w_wd_enable || (r_state == START));

    sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (w_expire)
    );

    // A model completes on a finish seen after the first RENDER cycle, or on expiry
    assign w_advance = ((r_state == RENDER) &&
                        (w_expire || (!r_render_first && i_render_finished))) ||
                       ((r_state == WAIT_READY) && w_expire);

    // Single-cycle pulse whenever the watchdog forces a model skip
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
        end
    end

    assign o_timeout = r_timeout;
`else
    // The first RENDER cycle may still see the previous model's latched finish
    assign w_advance = (r_state == RENDER) && !r_render_first && i_render_finished;
`endif

    // Frame sequencing state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_model_idx    <= '0;
            r_render_first <= 1'b0;
            r_clear_start  <= 1'b0;
            r_render_start <= 1'b0;
            r_swap_req     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_clear_start  <= 1'b0;
            r_render_start <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overrun      <= i_frame_start && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (i_frame_start) begin
                        r_state       <= CLEAR;
                        r_count       <= w_count_sat;
                        r_model_idx   <= '0;
                        r_clear_start <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (i_clear_done) begin
                        if (r_count == '0) begin
                            r_state    <= SWAP;
                            r_swap_req <= 1'b1;
                        end else begin
                            r_state <= WAIT_READY;
                        end
                    end
                end
                WAIT_READY: begin
                    if (w_advance) begin
                        r_model_idx <= w_next_idx;
                        if (w_next_idx < r_count) begin
                            r_state <= WAIT_READY;
                        end else begin
                            r_state    <= SWAP;
                            r_swap_req <= 1'b1;
                        end
                    end else if (i_render_ready) begin
                        r_state        <= START;
                        r_render_start <= 1'b1;
                    end
                end
                START: begin
                    r_state        <= RENDER;
                    r_render_first <= 1'b1;
                end
                RENDER: begin
                    r_render_first <= 1'b0;
                    if (w_advance) begin
                        r_model_idx <= w_next_idx;
                        if (w_next_idx < r_count) begin
                            r_state <= WAIT_READY;
                        end else begin
                            r_state    <= SWAP;
                            r_swap_req <= 1'b1;
                        end
                    end
                end
                SWAP: begin
                    if (i_swap_ack) begin
                        r_state      <= DONE;
                        r_swap_req   <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy         = (r_state != IDLE);
    assign o_clear_start  = r_clear_start;
    assign o_render_start = r_render_start;
    assign o_model_idx    = r_model_idx;
    assign o_swap_req     = r_swap_req;
    assign o_frame_done   = r_frame_done;
    assign o_overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_scheduler
//  Purpose  : Directed self-checking bench for frame_scheduler with simple
//             clear/render/swap responders and pulse monitors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_scheduler;

    localparam int c_MW = 7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            frame_start = 1'b0;
    logic [c_MW-1:0] model_count = '0;
    logic            busy, clear_start, render_start, swap_req, frame_done, overrun;
    logic [c_MW-1:0] model_idx;
    logic            rend_ready = 1'b1;
    logic            rend_fin = 1'b0;
    logic            clr_auto = 1'b0, clr_manual = 1'b0;
    logic            ack_auto = 1'b0, ack_manual = 1'b0;
    wire             clear_done = clr_auto | clr_manual;
    wire             swap_ack   = ack_auto | ack_manual;
`ifdef FRAME_SCHED_TIMEOUT_EN
    logic            timeout;
`endif

    int n_cmp = 0, n_fail = 0;
    int n_clear = 0, n_start = 0, n_done = 0, n_over = 0, n_swap = 0, n_tmo = 0;
    int idx_log[256];
    int fin_cnt = -1, clr_cnt = 0, ack_cnt = 0;
    bit fin_enable = 1'b1;
    localparam int c_FIN_DELAY = 10;

    frame_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_frame_start     (frame_start),
        .i_model_count     (model_count),
        .o_busy            (busy),
        .o_clear_start     (clear_start),
        .i_clear_done      (clear_done),
        .o_render_start    (render_start),
        .i_render_ready    (rend_ready),
        .i_render_finished (rend_fin),
        .o_model_idx       (model_idx),
        .o_swap_req        (swap_req),
        .i_swap_ack        (swap_ack),
        .o_frame_done      (frame_done),
        .o_overrun         (overrun)
`ifdef FRAME_SCHED_TIMEOUT_EN
        ,
        .o_timeout         (timeout)
`endif
    );

    always #5 clk = ~clk;

    // Pulse monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (clear_start) n_clear++;
        if (render_start) begin
            idx_log[n_start % 256] = int'(model_idx);
            n_start++;
        end
        if (frame_done) n_done++;
        if (overrun) n_over++;
        if (swap_req) n_swap++;
`ifdef FRAME_SCHED_TIMEOUT_EN
        if (timeout) n_tmo++;
`endif
    end

    // Responders: clear done 2 cycles after clear start, ack 2 cycles into
    // the swap request, render finish latched c_FIN_DELAY cycles after start
    always @(negedge clk) begin
        if (clr_cnt != 0) clr_cnt++;
        else if (clear_start) clr_cnt = 1;
        clr_auto = (clr_cnt == 3);
        if (clr_cnt == 3) clr_cnt = 0;

        if (ack_cnt != 0) ack_cnt++;
        else if (swap_req) ack_cnt = 1;
        ack_auto = (ack_cnt == 3);
        if (ack_cnt == 3) ack_cnt = 0;

        if (render_start) fin_cnt = 0;
        else if (fin_cnt >= 0) fin_cnt++;
        if (fin_cnt == 2) rend_fin = 1'b0;
        if (fin_enable && fin_cnt == c_FIN_DELAY) begin
            rend_fin = 1'b1;
            fin_cnt  = -1;
        end
    end

    task automatic start_frame(input int cnt);
        @(negedge clk);
        frame_start = 1'b1;
        model_count = c_MW'(cnt);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_start(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_start > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6+c_MW-1:0] v;
        repeat (3) @(negedge clk);
        v = {busy, clear_start, render_start, swap_req, frame_done, overrun, model_idx};
        n_cmp++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h expected 0", v);
        end
        rst = 1'b0;
        @(negedge clk);
        v = {busy, clear_start, render_start, swap_req, frame_done, overrun, model_idx};
        n_cmp++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h expected 0", v);
        end
    endtask

    task automatic test_three_models();
        int b_st, b_dn, b_cl, b_sw;
        bit ok;
        b_st = n_start; b_dn = n_done; b_cl = n_clear; b_sw = n_swap;
        start_frame(3);
        n_cmp++;
        if (clear_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL three_clear_pulse: clear_start=%b busy=%b expected 1 1", clear_start, busy);
        end
        wait_done(b_dn, 1000, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL three_done_timeout: no frame_done within budget");
        end
        n_cmp++;
        if (n_start - b_st !== 3) begin
            n_fail++;
            $display("FAIL three_start_count: got %0d expected 3", n_start - b_st);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (idx_log[(b_st + k) % 256] !== k) begin
                n_fail++;
                $display("FAIL three_idx%0d: got %0d expected %0d", k, idx_log[(b_st + k) % 256], k);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (n_done - b_dn !== 1 || n_clear - b_cl !== 1 || n_swap - b_sw < 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL three_tail: done=%0d clear=%0d swap=%0d busy=%b expected 1 1 >=1 0",
                     n_done - b_dn, n_clear - b_cl, n_swap - b_sw, busy);
        end
    endtask

    task automatic test_zero_count();
        int b_st, b_dn, b_cl, b_sw;
        bit ok;
        b_st = n_start; b_dn = n_done; b_cl = n_clear; b_sw = n_swap;
        start_frame(0);
        wait_done(b_dn, 200, ok);
        @(negedge clk);
        n_cmp++;
        if (!ok || n_start - b_st !== 0 || n_clear - b_cl !== 1 || n_swap - b_sw < 1 || n_done - b_dn !== 1) begin
            n_fail++;
            $display("FAIL zero_count: done_ok=%b starts=%0d clears=%0d swaps=%0d dones=%0d expected 1 0 1 >=1 1",
                     ok, n_start - b_st, n_clear - b_cl, n_swap - b_sw, n_done - b_dn);
        end
    endtask

    task automatic test_stale_finish();
        int b_st, b_dn;
        bit ok;
        b_st = n_start; b_dn = n_done;
        start_frame(1);
        wait_start(b_st, 200, ok);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (!ok || swap_req !== 1'b0 || busy !== 1'b1 || model_idx !== c_MW'(0)) begin
            n_fail++;
            $display("FAIL stale_finish: start_ok=%b swap_req=%b busy=%b idx=%0d expected 1 0 1 0",
                     ok, swap_req, busy, model_idx);
        end
        wait_done(b_dn, 300, ok);
        n_cmp++;
        if (!ok || n_start - b_st !== 1) begin
            n_fail++;
            $display("FAIL stale_complete: done_ok=%b starts=%0d expected 1 1", ok, n_start - b_st);
        end
    endtask

    task automatic test_overrun();
        int b_st, b_dn, b_cl, b_ov;
        bit ok;
        b_st = n_start; b_dn = n_done; b_cl = n_clear; b_ov = n_over;
        start_frame(2);
        wait_start(b_st, 200, ok);
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        model_count = c_MW'(5);
        @(negedge clk);
        frame_start = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_pulse: overrun=%b expected 1", overrun);
        end
        @(negedge clk);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_single: overrun=%b expected 0", overrun);
        end
        wait_done(b_dn, 400, ok);
        @(negedge clk);
        n_cmp++;
        if (!ok || n_start - b_st !== 2 || n_clear - b_cl !== 1 || n_over - b_ov !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_frame: done_ok=%b starts=%0d clears=%0d overruns=%0d busy=%b expected 1 2 1 1 0",
                     ok, n_start - b_st, n_clear - b_cl, n_over - b_ov, busy);
        end
    endtask

    task automatic test_reset_mid_render();
        int b_st, b_dn;
        bit ok;
        logic [6+c_MW-1:0] v;
        b_st = n_start; b_dn = n_done;
        start_frame(3);
        wait_start(b_st, 200, ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        v = {busy, clear_start, render_start, swap_req, frame_done, overrun, model_idx};
        n_cmp++;
        if (!ok || v !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_render: start_ok=%b outputs=%h expected 1 0", ok, v);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        v = {busy, clear_start, render_start, swap_req, frame_done, overrun, model_idx};
        n_cmp++;
        if (v !== '0 || n_done !== b_dn) begin
            n_fail++;
            $display("FAIL reset_abort: outputs=%h dones=%0d expected 0 0", v, n_done - b_dn);
        end
        b_dn = n_done;
        start_frame(1);
        wait_done(b_dn, 300, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_recover: no frame_done after reset");
        end
    endtask

    task automatic test_stray_and_ready();
        int b_st, b_dn;
        bit ok;
        @(negedge clk);
        clr_manual = 1'b1;
        ack_manual = 1'b1;
        @(negedge clk);
        clr_manual = 1'b0;
        ack_manual = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, swap_req, frame_done, clear_start} !== 4'b0) begin
            n_fail++;
            $display("FAIL stray_idle: busy/swap/done/clear=%b expected 0000",
                     {busy, swap_req, frame_done, clear_start});
        end
        b_st = n_start; b_dn = n_done;
        rend_ready = 1'b0;
        start_frame(1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_start !== b_st || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_gate: starts=%0d busy=%b expected 0 1", n_start - b_st, busy);
        end
        rend_ready = 1'b1;
        wait_done(b_dn, 300, ok);
        n_cmp++;
        if (!ok || n_start - b_st !== 1) begin
            n_fail++;
            $display("FAIL ready_release: done_ok=%b starts=%0d expected 1 1", ok, n_start - b_st);
        end
    endtask

    task automatic test_saturation();
        int b_st, b_dn;
        bit ok;
        b_st = n_start; b_dn = n_done;
        start_frame(100);
        wait_done(b_dn, 3000, ok);
        n_cmp++;
        if (!ok || n_start - b_st !== 64 || idx_log[(b_st + 63) % 256] !== 63) begin
            n_fail++;
            $display("FAIL saturation: done_ok=%b starts=%0d last_idx=%0d expected 1 64 63",
                     ok, n_start - b_st, idx_log[(b_st + 63) % 256]);
        end
    endtask

`ifdef FRAME_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int b_st, b_dn, b_tm;
        bit ok;
        b_st = n_start; b_dn = n_done; b_tm = n_tmo;
        fin_enable = 1'b0;
        rend_fin   = 1'b0;
        start_frame(2);
        wait_done(b_dn, 400, ok);
        n_cmp++;
        if (!ok || n_tmo - b_tm !== 2 || n_start - b_st !== 2) begin
            n_fail++;
            $display("FAIL timeout_skip: done_ok=%b timeouts=%0d starts=%0d expected 1 2 2",
                     ok, n_tmo - b_tm, n_start - b_st);
        end
        fin_enable = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_three_models();
        test_zero_count();
        test_stale_finish();
        test_overrun();
        test_reset_mid_render();
        test_stray_and_ready();
        test_saturation();
`ifdef FRAME_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
